// File: rtl/minterm_scanner_pkg.sv
// Shared definitions for the minterm scanner: FSM encodings, code width and
// the default truth mask.
package minterm_pkg;

  localparam int CODE_W = 4;
  localparam logic [15:0] MASK_APP2 = 16'h68A4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/minterm_scanner_match.sv
// Combinational lookup: does the 4-input function at code idx_i take the
// target value? Kept separate so other lab blocks can reuse the lookup.
module minterm_match
  import minterm_pkg::*;
#(
  parameter logic [15:0] TRUTH_MASK = MASK_APP2,
  parameter logic        TARGET     = 1'b1
) (
  input  logic [CODE_W-1:0] idx_i,
  output logic              match_o
);

  assign match_o = (TRUTH_MASK[idx_i] == TARGET);

endmodule

// File: rtl/minterm_scanner.sv
// Sweeps abcd = 0..15 on start and streams every code whose function value
// equals TARGET. Optional transfer counter enabled by MINTERM_SCAN_COUNT_EN.
module minterm_scanner
  import minterm_pkg::*;
#(
  parameter logic [15:0] TRUTH_MASK = MASK_APP2,
  parameter logic        TARGET     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              busy,
  output logic              done
`ifdef MINTERM_SCAN_COUNT_EN
  ,
  output logic [4:0]        count
`endif
);

  // Stream handshake: code is offered while code_valid is high and is held
  // stable until code_valid & code_ready on a rising edge retires it.

  state_e            state_q;
  logic [CODE_W-1:0] idx_q;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              match;
  logic              xfer;

  minterm_match #(
    .TRUTH_MASK(TRUTH_MASK),
    .TARGET    (TARGET)
  ) u_match (
    .idx_i  (idx_q),
    .match_o(match)
  );

  assign xfer = valid_q & code_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (match) begin
            code_q  <= idx_q;
            valid_q <= 1'b1;
            state_q <= ST_EMIT;
          end else if (idx_q == 4'hF) begin
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        ST_EMIT: begin
          if (xfer) begin
            valid_q <= 1'b0;
            // idx 15 ends the sweep explicitly rather than wrapping to 0
            if (idx_q == 4'hF) begin
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= ST_SCAN;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MINTERM_SCAN_COUNT_EN
  logic [4:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      count_q <= '0;
    end else if (state_q == ST_EMIT && xfer) begin
      count_q <= count_q + 5'd1;
    end
  end

  assign count = count_q;
`endif

  assign code       = code_q;
  assign code_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_minterm_scanner.sv
// Bench for minterm_scanner: four instances (default, maxterms, empty mask,
// full mask) share clock, reset and start; each has its own expected queue.
module tb_minterm_scanner;

  localparam logic [15:0] MASK_T [4] = '{16'h68A4, 16'h68A4, 16'h0000, 16'hFFFF};
  localparam logic        TGT_T  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] code_w  [4];
  logic       valid_w [4];
  logic       ready   [4];
  logic       busy_w  [4];
  logic       done_w  [4];
`ifdef MINTERM_SCAN_COUNT_EN
  logic [4:0] count_w [4];
`endif

  logic [3:0] exp_q [4][$];
  int n_exp    [4];
  int done_cnt [4];
  int done_cyc [4];
  int cyc;
  int s_cyc;
  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  minterm_scanner #(.TRUTH_MASK(MASK_T[0]), .TARGET(TGT_T[0])) u_def (
    .clk(clk), .rst_n(rst_n), .start(start), .code(code_w[0]),
    .code_valid(valid_w[0]), .code_ready(ready[0]), .busy(busy_w[0]), .done(done_w[0])
`ifdef MINTERM_SCAN_COUNT_EN
    , .count(count_w[0])
`endif
  );

  minterm_scanner #(.TRUTH_MASK(MASK_T[1]), .TARGET(TGT_T[1])) u_max (
    .clk(clk), .rst_n(rst_n), .start(start), .code(code_w[1]),
    .code_valid(valid_w[1]), .code_ready(ready[1]), .busy(busy_w[1]), .done(done_w[1])
`ifdef MINTERM_SCAN_COUNT_EN
    , .count(count_w[1])
`endif
  );

  minterm_scanner #(.TRUTH_MASK(MASK_T[2]), .TARGET(TGT_T[2])) u_zero (
    .clk(clk), .rst_n(rst_n), .start(start), .code(code_w[2]),
    .code_valid(valid_w[2]), .code_ready(ready[2]), .busy(busy_w[2]), .done(done_w[2])
`ifdef MINTERM_SCAN_COUNT_EN
    , .count(count_w[2])
`endif
  );

  minterm_scanner #(.TRUTH_MASK(MASK_T[3]), .TARGET(TGT_T[3])) u_all (
    .clk(clk), .rst_n(rst_n), .start(start), .code(code_w[3]),
    .code_valid(valid_w[3]), .code_ready(ready[3]), .busy(busy_w[3]), .done(done_w[3])
`ifdef MINTERM_SCAN_COUNT_EN
    , .count(count_w[3])
`endif
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: compare each transfer against the expected queue, count done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (valid_w[k] && ready[k]) begin
          check_eq($sformatf("xfer_expected[%0d]", k), 32'(exp_q[k].size() > 0), 1);
          if (exp_q[k].size() > 0)
            check_eq($sformatf("code[%0d]", k), 32'(code_w[k]), 32'(exp_q[k].pop_front()));
        end
        if (done_w[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic push_expected();
    logic [15:0] m;
    for (int k = 0; k < 4; k++) begin
      m = MASK_T[k];
      n_exp[k] = 0;
      for (int i = 0; i < 16; i++) begin
        if (m[i] == TGT_T[k]) begin
          exp_q[k].push_back(4'(i));
          n_exp[k]++;
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  // One full sweep. hold_code>=0 stalls instance 0 for hold_len cycles on that
  // code; restart_at>0 re-pulses start that many cycles into the sweep.
  task automatic run_scan(input int hold_code, input int hold_len, input int restart_at);
    int   base [4];
    int   held;
    int   c;
    int   extra;
    logic all_done;
    for (int k = 0; k < 4; k++) base[k] = done_cnt[k];
    push_expected();
    pulse_start();
    for (int k = 0; k < 4; k++) check_eq($sformatf("busy_after_start[%0d]", k), 32'(busy_w[k]), 1);
    held = 0;
    c = 0;
    all_done = 1'b0;
    while (!all_done && c < 120) begin
      @(posedge clk); #1;
      c++;
      start = (c == restart_at);
      if (held > 0 && held < hold_len) begin
        check_eq("hold_code", 32'(code_w[0]), hold_code);
        check_eq("hold_valid", 32'(valid_w[0]), 1);
        ready[0] = 1'b0;
        held++;
      end else if (held == 0 && hold_code >= 0 && valid_w[0] && 32'(code_w[0]) == hold_code) begin
        ready[0] = 1'b0;
        held = 1;
      end else begin
        ready[0] = 1'b1;
      end
      all_done = 1'b1;
      for (int k = 0; k < 4; k++) if (done_cnt[k] == base[k]) all_done = 1'b0;
    end
    start = 1'b0;
    ready[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      extra = (k == 0 && hold_code >= 0) ? hold_len : 0;
      check_eq($sformatf("done_pulses[%0d]", k), done_cnt[k] - base[k], 1);
      check_eq($sformatf("done_cycle[%0d]", k), done_cyc[k] - s_cyc, 17 + n_exp[k] + extra);
      check_eq($sformatf("queue_drained[%0d]", k), exp_q[k].size(), 0);
      check_eq($sformatf("idle_busy[%0d]", k), 32'(busy_w[k]), 0);
`ifdef MINTERM_SCAN_COUNT_EN
      check_eq($sformatf("count[%0d]", k), 32'(count_w[k]), n_exp[k]);
`endif
    end
  endtask

  // Reset asserted while instance 0 holds code 7 in EMIT.
  task automatic reset_mid_emit();
    int   base [4];
    int   c;
    logic seen;
    push_expected();
    pulse_start();
    seen = 1'b0;
    c = 0;
    while (!seen && c < 60) begin
      @(posedge clk); #1;
      c++;
      if (valid_w[0] && code_w[0] == 4'd7) begin
        seen = 1'b1;
        ready[0] = 1'b0;
      end
    end
    check_eq("reached_code7", 32'(seen), 1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("stall_code7", 32'(code_w[0]), 7);
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(valid_w[0]), 0);
    check_eq("rst_busy", 32'(busy_w[0]), 0);
    check_eq("rst_code", 32'(code_w[0]), 0);
    check_eq("rst_done", 32'(done_w[0]), 0);
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      base[k] = done_cnt[k];
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready[0] = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("no_done_after_reset[%0d]", k), done_cnt[k] - base[k], 0);
      check_eq($sformatf("idle_after_reset[%0d]", k), 32'(busy_w[k]), 0);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ready[k] = 1'b1;
      done_cnt[k] = 0;
      done_cyc[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("reset_code[%0d]", k), 32'(code_w[k]), 0);
      check_eq($sformatf("reset_valid[%0d]", k), 32'(valid_w[k]), 0);
      check_eq($sformatf("reset_busy[%0d]", k), 32'(busy_w[k]), 0);
      check_eq($sformatf("reset_done[%0d]", k), 32'(done_w[k]), 0);
`ifdef MINTERM_SCAN_COUNT_EN
      check_eq($sformatf("reset_count[%0d]", k), 32'(count_w[k]), 0);
`endif
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_scan(-1, 0, -1);
    run_scan(5, 5, -1);
    run_scan(-1, 0, 5);
    reset_mid_emit();
    run_scan(-1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
